calc_input_ctrl: RTL

Front-end for the lab-2 calculator, producing the operand, operation-code and strobe signals that the calculator datapath consumes.
- Synchronizes and debounces the two raw push-buttons (next-operation and equals) and turns each press into a single-cycle pulse.
- Owns the wrapping operation-code register and freezes the operand switches when equals is pressed.
- Sits between the board pins (switches, KEY buttons) and the ALU/display top.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_input_ctrl_btn_debounce.sv | 81 ++++++++
 rtl/calc_input_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator input front-end.
// Optional sig auto-repeat is enabled with CALC_AUTOREPEAT_EN.
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_MOD,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR = 4'd9
    } op_t;

    typedef enum logic {
        EDIT = 1'b0,
        SHOW = 1'b1
    } ctrl_state_t;

    localparam logic [3:0] OP_LAST_C = 4'd9;

    function automatic logic [3:0] op_next(
        input logic [3:0] cur,
        input logic [3:0] last
    );
        return (cur == last) ? 4'd0 : cur + 4'd1;
    endfunction

endpackage

// File: rtl/calc_input_ctrl_btn_debounce.sv
// Button synchronizer, debouncer and press-pulse generator.
// With CALC_AUTOREPEAT_EN, REPEAT=1 adds held-button repeat pulses.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef CALC_AUTOREPEAT_EN
    ,
    parameter bit REPEAT = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          press;
    logic          fire;

    assign accept = (s2 != stable) && (cnt == CNT_MAX);
    assign press  = accept && !s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef CALC_AUTOREPEAT_EN
    localparam int RW = $clog2(4 * DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(4 * DEBOUNCE_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    assign rep_fire = REPEAT && !stable && (rep_cnt == REP_MAX);

    // Repeat period is measured from the edge that accepted the press.
    always_ff @(posedge clk) begin
        if (!rst_n || press || stable || rep_fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign fire = press || rep_fire;
`else
    assign fire = press;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= fire;
        end
    end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator front-end: button pulses, op register, operand freeze.
// Define CALC_AUTOREPEAT_EN for auto-repeat on the sig button.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [3:0] OP_LAST         = OP_LAST_C,
    parameter int         W               = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw_a,
    input  logic [W-1:0] sw_b,
    input  logic         btn_sig_n,
    input  logic         btn_equ_n,
    output logic [3:0]   op,
    output logic [W-1:0] a_q,
    output logic [W-1:0] b_q,
    output logic         op_step,
    output logic         equ_strobe,
    output logic         result_valid
);

    ctrl_state_t  state_q;
    ctrl_state_t  state_d;
    logic         latch;
    logic         advance;
    logic [W-1:0] a_s1;
    logic [W-1:0] a_s2;
    logic [W-1:0] b_s1;
    logic [W-1:0] b_s2;

`ifdef CALC_AUTOREPEAT_EN
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT         (1'b1)
    ) u_sig (
`else
    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sig (
`endif
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_sig_n),
        .pulse(op_step)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_equ (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_n(btn_equ_n),
        .pulse(equ_strobe)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1 <= '0;
            a_s2 <= '0;
            b_s1 <= '0;
            b_s2 <= '0;
        end else begin
            a_s1 <= sw_a;
            a_s2 <= a_s1;
            b_s1 <= sw_b;
            b_s2 <= b_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EDIT;
        end else begin
            state_q <= state_d;
        end
    end

    // equ wins over a coincident sig pulse; the sig press is dropped.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            EDIT: begin
                if (equ_strobe) begin
                    latch   = 1'b1;
                    state_d = SHOW;
                end else if (op_step) begin
                    advance = 1'b1;
                end
            end
            SHOW: begin
                if (equ_strobe) begin
                    latch = 1'b1;
                end else if (op_step) begin
                    advance = 1'b1;
                    state_d = EDIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op  <= 4'd0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (advance) begin
                op <= op_next(op, OP_LAST);
            end
            if (latch) begin
                a_q <= a_s2;
                b_q <= b_s2;
            end
        end
    end

    assign result_valid = (state_q == SHOW);

endmodule
